// File: rtl/intra16x16_mode_decider_pkg.sv
// Shared types and sizing for the 16x16 intra mode decider.
package intra_pkg;

  localparam int unsigned PIX_W     = 8;   // residual sample width, two's complement
  localparam int unsigned ROWS      = 16;  // rows per macroblock, samples per row
  localparam int unsigned SAD_W     = 16;  // full-macroblock SAD accumulator width
  localparam int unsigned CNT_W     = $clog2(ROWS);
  localparam int unsigned ROW_SUM_W = $clog2(ROWS) + PIX_W;  // one row of |s|

  // One residual row: ROWS signed samples, sample c at [c].
  typedef logic [ROWS-1:0][PIX_W-1:0] row_t;

  // Final SADs, indexed by mode: [0]=V, [1]=H, [2]=DC.
  typedef logic [2:0][SAD_W-1:0] sads_t;

  typedef enum logic [1:0] {
    I16_V  = 2'd0,
    I16_H  = 2'd1,
    I16_DC = 2'd2
  } i16_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/intra16x16_mode_decider_sad_row16.sv
// Sum of absolute values over one residual row. Magnitudes are taken on a
// sign-extended PIX_W+1 value so the most negative sample maps to +2^(PIX_W-1).
module sad_row16
  import intra_pkg::*;
(
  input  row_t                 row,
  output logic [ROW_SUM_W-1:0] sum
);

  logic [PIX_W:0] mag [ROWS];

  for (genvar i = 0; i < ROWS; i++) begin : g_mag
    logic signed [PIX_W:0] ext;
    assign ext    = {row[i][PIX_W-1], row[i]};
    assign mag[i] = ext[PIX_W] ? (PIX_W+1)'(-ext) : ext;
  end

  // Add the sixteen magnitudes; ROW_SUM_W holds ROWS * 2^(PIX_W-1) exactly.
  always_comb begin
    sum = '0;
    for (int i = 0; i < ROWS; i++) begin
      sum = sum + ROW_SUM_W'(mag[i]);
    end
  end

endmodule

// File: rtl/intra16x16_mode_decider.sv
// Sequences SAD evaluation of one 16x16 luma macroblock: streams V/H/DC
// residual rows, accumulates three SADs and picks the cheapest allowed mode.
//
// Row handshake: a row transfers on a rising clk edge where row_valid and
// row_ready are both 1. row_ready depends only on the controller state (never
// on row_valid); the source may hold row_valid low for any number of cycles
// and the controller simply waits.
module intra16x16_mode_decider
  import intra_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             avail_top,
  input  logic             avail_left,
  input  logic             row_valid,
  output logic             row_ready,
  input  row_t             vrow,
  input  row_t             hrow,
  input  row_t             dcrow,
  output logic             busy,
  output logic             done,
  output i16_mode_t        best_mode,
  output logic [SAD_W-1:0] best_sad,
  output sads_t            sads,
  output state_t           dbg_state
);

  // The worst-case macroblock SAD must fit the accumulator.
  if (SAD_W < PIX_W - 1 + 2 * $clog2(ROWS) + 1) begin : g_sad_w_check
    $error("SAD_W too narrow for ROWS*ROWS*2^(PIX_W-1)");
  end

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       row_cnt;
  logic [SAD_W-1:0]       acc_v, acc_h, acc_dc;
  logic                   top_q, left_q;
  logic [ROW_SUM_W-1:0]   sum_v, sum_h, sum_dc;
  logic                   row_accept;
  i16_mode_t              cmp_mode;
  logic [SAD_W-1:0]       cmp_sad;

  sad_row16 u_sad_v  (.row(vrow),  .sum(sum_v));
  sad_row16 u_sad_h  (.row(hrow),  .sum(sum_h));
  sad_row16 u_sad_dc (.row(dcrow), .sum(sum_dc));

  assign row_accept = row_valid & row_ready;
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one pass IDLE -> ACCUM -> COMPARE -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start) state_nxt = ST_ACCUM;
      ST_ACCUM:   if (row_accept && row_cnt == LAST_ROW) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    row_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE:    ;
      ST_ACCUM:   begin row_ready = 1'b1; busy = 1'b1; end
      ST_COMPARE: busy = 1'b1;
      ST_DONE:    begin busy = 1'b1; done = 1'b1; end
      default:    ;
    endcase
  end

  // Row counter, accumulators and neighbour-availability capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
      acc_v   <= '0;
      acc_h   <= '0;
      acc_dc  <= '0;
      top_q   <= 1'b0;
      left_q  <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      row_cnt <= '0;
      acc_v   <= '0;
      acc_h   <= '0;
      acc_dc  <= '0;
      top_q   <= avail_top;
      left_q  <= avail_left;
    end else if (state == ST_ACCUM && row_accept) begin
      row_cnt <= row_cnt + 1'b1;
      acc_v   <= acc_v  + SAD_W'(sum_v);
      acc_h   <= acc_h  + SAD_W'(sum_h);
      acc_dc  <= acc_dc + SAD_W'(sum_dc);
    end
  end

  // Cheapest allowed mode; checking DC, then H, then V with <= lets the
  // lower mode index win every tie.
  always_comb begin
    cmp_mode = I16_DC;
    cmp_sad  = acc_dc;
    if (left_q && acc_h <= cmp_sad) begin
      cmp_mode = I16_H;
      cmp_sad  = acc_h;
    end
    if (top_q && acc_v <= cmp_sad) begin
      cmp_mode = I16_V;
      cmp_sad  = acc_v;
    end
  end

  // Result registers: loaded in COMPARE, held until the next COMPARE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_mode <= I16_DC;
      best_sad  <= '0;
      sads      <= '0;
    end else if (state == ST_COMPARE) begin
      best_mode <= cmp_mode;
      best_sad  <= cmp_sad;
      sads[0]   <= acc_v;
      sads[1]   <= acc_h;
      sads[2]   <= acc_dc;
    end
  end

endmodule

// File: tb/tb_intra16x16_mode_decider.sv
// Directed and randomized macroblocks against a whole-block SAD model.
module tb_intra16x16_mode_decider;
  import intra_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             start = 1'b0;
  logic             avail_top = 1'b0;
  logic             avail_left = 1'b0;
  logic             row_valid = 1'b0;
  logic             row_ready;
  row_t             vrow = '0;
  row_t             hrow = '0;
  row_t             dcrow = '0;
  logic             busy;
  logic             done;
  i16_mode_t        best_mode;
  logic [SAD_W-1:0] best_sad;
  sads_t            sads;
  state_t           dbg_state;

  intra16x16_mode_decider dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .avail_top  (avail_top),
    .avail_left (avail_left),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .vrow       (vrow),
    .hrow       (hrow),
    .dcrow      (dcrow),
    .busy       (busy),
    .done       (done),
    .best_mode  (best_mode),
    .best_sad   (best_sad),
    .sads       (sads),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // smp[mode][row][col], mode 0=V 1=H 2=DC, values in [-128,127]
  int smp [3][ROWS][ROWS];
  int exp_sad [3];
  int exp_mode;
  int exp_best;
  int done_count = 0;

  always @(posedge clk) if (done) done_count <= done_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // kind: 0 zero, 1 V=+1/H=-2/DC=+3, 2 all -128, 3 random, 4 all +1
  task automatic fill(input int kind);
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < ROWS; c++)
          case (kind)
            0: smp[m][r][c] = 0;
            1: smp[m][r][c] = (m == 0) ? 1 : (m == 1) ? -2 : 3;
            2: smp[m][r][c] = -128;
            3: smp[m][r][c] = int'($urandom_range(0, 255)) - 128;
            default: smp[m][r][c] = 1;
          endcase
  endtask

  // Reference: total |s| per mode over the whole block, then the first
  // allowed mode (in V, H, DC order) holding the strictly smallest total.
  task automatic model(input bit top, input bit left);
    bit allowed [3];
    allowed[0] = top;
    allowed[1] = left;
    allowed[2] = 1'b1;
    for (int m = 0; m < 3; m++) begin
      exp_sad[m] = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < ROWS; c++)
          exp_sad[m] += (smp[m][r][c] < 0) ? -smp[m][r][c] : smp[m][r][c];
    end
    exp_mode = -1;
    for (int m = 0; m < 3; m++)
      if (allowed[m] && (exp_mode < 0 || exp_sad[m] < exp_best)) begin
        exp_mode = m;
        exp_best = exp_sad[m];
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_row(input int r);
    for (int c = 0; c < ROWS; c++) begin
      vrow[c]  = 8'(smp[0][r][c]);
      hrow[c]  = 8'(smp[1][r][c]);
      dcrow[c] = 8'(smp[2][r][c]);
    end
  endtask

  // Present rows until n handshakes; optional random gaps and start noise.
  task automatic feed_rows(input int n, input bit gaps, output int last_hs_cyc);
    int r = 0;
    int guard = 0;
    bit hs;
    last_hs_cyc = -1;
    while (r < n && guard < 400) begin
      drive_row(r);
      row_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gaps) start = 1'($urandom_range(0, 1));
      hs = row_valid && row_ready;
      if (hs) last_hs_cyc = cyc;
      @(posedge clk); #1;
      if (hs) r++;
      guard++;
    end
    row_valid = 1'b0;
    start = 1'b0;
    check("rows_accepted", r, n);
  endtask

  task automatic run_mb(input string name, input bit top, input bit left, input bit gaps);
    int start_cyc;
    int hs_cyc;
    int n;
    int dc0;
    model(top, left);
    avail_top  = top;
    avail_left = left;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    avail_top  = $urandom_range(0, 1);   // latched values must be used
    avail_left = $urandom_range(0, 1);
    check({name, "_busy_rise"}, busy, 1);
    dc0 = done_count;
    feed_rows(ROWS, gaps, hs_cyc);
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, done, 1);
    check({name, "_done_after_hs"}, cyc - hs_cyc, 2);
    if (!gaps) check({name, "_start_to_done"}, cyc - start_cyc + 1, 19);
    check({name, "_busy_in_done"}, busy, 1);
    check({name, "_sad_v"},  sads[0], exp_sad[0]);
    check({name, "_sad_h"},  sads[1], exp_sad[1]);
    check({name, "_sad_dc"}, sads[2], exp_sad[2]);
    check({name, "_best_mode"}, best_mode, exp_mode);
    check({name, "_best_sad"},  best_sad, exp_best);
    @(posedge clk); #1;
    check({name, "_done_pulses"}, done_count - dc0, 1);
    check({name, "_idle_after"}, {busy, done, row_ready}, 0);
    check({name, "_held_best"}, best_sad, exp_best);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_row_ready"}, row_ready, 0);
    check({name, "_state"}, dbg_state, ST_IDLE);
    check({name, "_best_mode"}, best_mode, I16_DC);
    check({name, "_best_sad"}, best_sad, 0);
    check({name, "_sads"}, sads, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hs_cyc;
    int dc0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    fill(0);
    run_mb("zero", 1, 1, 0);

    fill(1);
    run_mb("pat_both", 1, 1, 0);
    run_mb("pat_no_top", 0, 1, 0);
    run_mb("pat_none", 0, 0, 0);

    fill(2);
    run_mb("neg128", 1, 1, 0);

    fill(1);
    run_mb("pat_gaps", 1, 1, 1);

    for (int k = 0; k < 6; k++) begin
      fill(3);
      run_mb("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort after row 7 (eight rows accepted), then a clean block.
    fill(1);
    avail_top = 1'b1;
    avail_left = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc0 = done_count;
    feed_rows(8, 0, hs_cyc);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", done_count - dc0, 0);
    check("abort_idle", dbg_state, ST_IDLE);

    fill(4);
    run_mb("after_abort", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
